alu_operand_sequencer: RTL and testbench
========================================

Name: alu_operand_sequencer

Overview:
Front end that builds operands for the board ALU instead of reading them straight from the switches. The user steps through function select, operand A and operand B on SW[7:0], confirming each value with a debounced push-button. The block then issues the captured word to the ALU over a valid/ready handshake and holds it for display until the next entry. It sits between the board switches/KEYs and the ALU datapath, and provides a status nibble for a spare hex digit.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive stable synchronized samples required before a key level is accepted (10 ms at 50 MHz); counter width is $clog2(DEBOUNCE_CYCLES+1).
TIMEOUT_CYCLES, 250000000, inactivity limit used only when the optional feature is compiled in.

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
sw  in  8  raw board switches, treated as static between key presses
key_n  in  2  raw push-buttons, active-low, asynchronous; [0]=enter, [1]=clear
alu_ready  in  1  ALU accepts the issued word when high
alu_valid  out  1  issued word is valid
func  out  3  captured function code
op_a  out  4  captured operand A
op_b  out  4  captured operand B
carry_in  out  1  captured carry-in
status  out  4  state code for the hex decoder: 1=FUNC, 2=A, 3=B, 4=ISSUE, 5=DONE

Behaviour:
- Key path, per key: two-flop synchronizer, then debounce counter. The counter resets whenever the synced sample differs from the debounced level. The debounced level flips after DEBOUNCE_CYCLES equal differing samples. A one-cycle press pulse fires on a debounced 1->0 transition. Key held low gives exactly one pulse. Release produces no pulse.
- Latency: if key_n is first sampled low at edge N and stays low, the press pulse is high in cycle N+2+DEBOUNCE_CYCLES.
- FSM states (status code):
  - S_FUNC (1): on enter, func<=sw[2:0] and carry_in<=sw[3]; go to S_A.
  - S_A (2): on enter, op_a<=sw[3:0]; go to S_B.
  - S_B (3): on enter, op_b<=sw[7:4]; go to S_ISSUE.
  - S_ISSUE (4): alu_valid=1; func/op_a/op_b/carry_in stay stable. On a cycle with alu_valid&alu_ready, go to S_DONE next cycle and drop alu_valid.
  - S_DONE (5): operands held; on enter, go to S_FUNC. Captured values are kept until overwritten.
- Clear press in any state: go to S_FUNC and zero func, op_a, op_b, carry_in and alu_valid next cycle.
- Enter and clear pulses in the same cycle: clear wins.
- Enter pulses while in S_ISSUE are ignored; there is no queueing.
- alu_valid is registered and never deasserts before a handshake unless clear or reset occurs.
- alu_ready high outside S_ISSUE has no effect.
- func values 6 and 7 are passed through unchanged; the ALU applies its default.
- Reset, including mid-issue: state S_FUNC, status=1, alu_valid=0, func=0, op_a=0, op_b=0, carry_in=0, synchronizers=1, debounced levels=1 (released), debounce counters=0, no pulse.

Optional Feature:
SEQ_IDLE_TIMEOUT_EN
- Defined: a counter clears on any press pulse and increments in S_FUNC, S_A and S_B. On reaching TIMEOUT_CYCLES it acts exactly as a clear. It does not run in S_ISSUE or S_DONE.
- Undefined: no counter is built and entry states wait indefinitely.

Decomposition:
- Package alu_seq_pkg:
  - state enum with the status codes above.
  - func code constants: 0 ripple add, 1 plus, 2 logic, 3 or-reduce, 4 pattern match, 5 invert.
  - widths FUNC_W=3, NIB_W=4.
- Sub-module key_conditioner (synchronizer + debounce + press pulse), parameterized by DEBOUNCE_CYCLES, instantiated once per key.

Test Plan:
- DEBOUNCE_CYCLES=4. reset, then key_n[0] held low 20 cycles -> exactly one press pulse, at edge N+6; state 1->2.
- key_n[0] toggling every 2 cycles for 30 cycles, then steady high -> no pulse, state unchanged.
- sw=8'h0B, enter; sw=8'h05, enter; sw=8'h30, enter; alu_ready=0 for 5 cycles, then 1 -> func=3, carry_in=1, op_a=5, op_b=3; alu_valid high for 6 cycles; status 4 then 5.
- In S_ISSUE, enter and clear pressed simultaneously -> S_FUNC next cycle, alu_valid=0, all operands 0.
- reset asserted for one cycle while alu_valid=1 -> next cycle all outputs at reset values and status=1.
- With SEQ_IDLE_TIMEOUT_EN and TIMEOUT_CYCLES=50, enter one digit then idle 50 cycles -> returns to S_FUNC with operands zeroed; in S_DONE no timeout occurs.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU operand sequencer:
// state/status codes, ALU function codes and the captured operand word.
package alu_seq_pkg;

  localparam int FUNC_W = 3;
  localparam int NIB_W  = 4;

  // Enum values are the status codes shown on the spare hex digit
  typedef enum logic [3:0] {
    S_FUNC  = 4'd1,
    S_A     = 4'd2,
    S_B     = 4'd3,
    S_ISSUE = 4'd4,
    S_DONE  = 4'd5
  } state_e;

  localparam logic [FUNC_W-1:0] F_RIPPLE_ADD = 3'd0;
  localparam logic [FUNC_W-1:0] F_PLUS       = 3'd1;
  localparam logic [FUNC_W-1:0] F_LOGIC      = 3'd2;
  localparam logic [FUNC_W-1:0] F_OR_REDUCE  = 3'd3;
  localparam logic [FUNC_W-1:0] F_PATTERN    = 3'd4;
  localparam logic [FUNC_W-1:0] F_INVERT     = 3'd5;

  typedef struct packed {
    logic [FUNC_W-1:0] func;
    logic              carry_in;
    logic [NIB_W-1:0]  op_a;
    logic [NIB_W-1:0]  op_b;
  } alu_word_t;

endpackage

// File: rtl/alu_operand_sequencer_key_conditioner.sv
// key_conditioner: two-flop synchronizer, debounce counter and a one-cycle
// press pulse on each debounced 1->0 transition of an active-low key.
module key_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clock,
  input  logic reset,
  input  logic key_n,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    sync;
  logic          level;
  logic          level_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync    <= 2'b11;
      level   <= 1'b1;
      level_d <= 1'b1;
      cnt     <= '0;
      press   <= 1'b0;
    end else begin
      sync    <= {sync[0], key_n};
      level_d <= level;
      press   <= level_d & ~level;
      // Any agreeing sample restarts the run of differing samples
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        level <= sync[1];
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_operand_sequencer.sv
// alu_operand_sequencer: steps func / A / B entry from the switches on debounced
// enter presses, then issues the captured word to the ALU over valid/ready.
// Optional build macro SEQ_IDLE_TIMEOUT_EN adds an entry-state inactivity clear.
module alu_operand_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
`ifdef SEQ_IDLE_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 250000000
`endif
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [7:0]        sw,
  input  logic [1:0]        key_n,
  input  logic              alu_ready,
  output logic              alu_valid,
  output logic [FUNC_W-1:0] func,
  output logic [NIB_W-1:0]  op_a,
  output logic [NIB_W-1:0]  op_b,
  output logic              carry_in,
  output logic [3:0]        status
);

  logic [1:0] press;
  logic       enter;
  logic       clr;
  logic       tmo_hit;
  state_e     state, state_nx;
  alu_word_t  word;

  for (genvar k = 0; k < 2; k++) begin : g_key
    key_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
      .clock (clock),
      .reset (reset),
      .key_n (key_n[k]),
      .press (press[k])
    );
  end

  assign enter = press[0];
  assign clr   = press[1] | tmo_hit;

`ifdef SEQ_IDLE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;
  logic          entry;

  assign entry   = (state == S_FUNC) || (state == S_A) || (state == S_B);
  assign tmo_hit = entry && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock) begin
    if (reset || (|press) || !entry || tmo_hit) tmo_cnt <= '0;
    else                                        tmo_cnt <= tmo_cnt + 1'b1;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) state <= S_FUNC;
    else       state <= state_nx;
  end

  // Clear overrides everything, including a simultaneous enter
  always_comb begin
    state_nx = state;
    if (clr) begin
      state_nx = S_FUNC;
    end else begin
      case (state)
        S_FUNC:  if (enter) state_nx = S_A;
        S_A:     if (enter) state_nx = S_B;
        S_B:     if (enter) state_nx = S_ISSUE;
        S_ISSUE: if (alu_valid && alu_ready) state_nx = S_DONE;
        S_DONE:  if (enter) state_nx = S_FUNC;
        default: state_nx = S_FUNC;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset || clr) begin
      word      <= '0;
      alu_valid <= 1'b0;
    end else begin
      alu_valid <= (state_nx == S_ISSUE);
      if (enter) begin
        case (state)
          S_FUNC: begin
            word.func     <= sw[2:0];
            word.carry_in <= sw[3];
          end
          S_A:     word.op_a <= sw[3:0];
          S_B:     word.op_b <= sw[7:4];
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    status   = 4'(state);
    func     = word.func;
    carry_in = word.carry_in;
    op_a     = word.op_a;
    op_b     = word.op_b;
  end

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Scoreboard bench for alu_operand_sequencer with a short debounce window:
// stimulus pushes expected issued words, a monitor pops them on each handshake.
module tb_alu_operand_sequencer;

  localparam int D = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] sw = 8'h00;
  logic [1:0] key_n = 2'b11;
  logic       alu_ready = 1'b0;
  logic       alu_valid;
  logic [2:0] func;
  logic [3:0] op_a;
  logic [3:0] op_b;
  logic       carry_in;
  logic [3:0] status;

  int n_cmp = 0;
  int n_bad = 0;
  logic [11:0] exp_q[$];

  alu_operand_sequencer #(.DEBOUNCE_CYCLES(D)) dut (
    .clock     (clock),
    .reset     (reset),
    .sw        (sw),
    .key_n     (key_n),
    .alu_ready (alu_ready),
    .alu_valid (alu_valid),
    .func      (func),
    .op_a      (op_a),
    .op_b      (op_b),
    .carry_in  (carry_in),
    .status    (status)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Full press and release; enough cycles for both edges to debounce
  task automatic press_key(input int k);
    key_n[k] = 1'b0;
    wait_neg(D + 4);
    key_n[k] = 1'b1;
    wait_neg(D + 4);
  endtask

  task automatic enter_val(input logic [7:0] v);
    sw = v;
    press_key(0);
  endtask

  task automatic chk_word(input string name, input logic [2:0] f, input logic c,
                          input logic [3:0] a, input logic [3:0] b);
    chk({name, "_func"}, 16'(func), 16'(f));
    chk({name, "_carry"}, 16'(carry_in), 16'(c));
    chk({name, "_op_a"}, 16'(op_a), 16'(a));
    chk({name, "_op_b"}, 16'(op_b), 16'(b));
  endtask

  // Monitor: compare every accepted word against the scoreboard
  always @(negedge clock) begin
    #2;
    if (!reset && alu_valid && alu_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_issue: got %0h expected none", {func, carry_in, op_a, op_b});
      end else begin
        chk("issued_word", 16'({func, carry_in, op_a, op_b}), 16'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int w;
    wait_neg(2);
    chk("rst_status", 16'(status), 16'd1);
    chk("rst_valid", 16'(alu_valid), 16'd0);
    chk_word("rst", 3'd0, 1'b0, 4'd0, 4'd0);
    reset = 1'b0;
    wait_neg(2);

    // Long hold: one pulse in cycle N+2+D, state visible one edge later
    key_n[0] = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clock);
      #1;
      chk($sformatf("hold_status_%0d", i), 16'(status), (i >= D + 3) ? 16'd2 : 16'd1);
    end
    @(negedge clock);
    key_n[0] = 1'b1;
    wait_neg(D + 4);
    chk("release_no_pulse", 16'(status), 16'd2);

    // Bounce shorter than the debounce window
    for (int i = 0; i < 15; i++) begin
      key_n[0] = i[0];
      wait_neg(2);
    end
    key_n[0] = 1'b1;
    wait_neg(10);
    chk("bounce_status", 16'(status), 16'd2);

    press_key(1);
    chk("clear_status", 16'(status), 16'd1);

    // Full entry then a delayed handshake
    alu_ready = 1'b0;
    enter_val(8'h0B);
    chk("func_status", 16'(status), 16'd2);
    chk("func_cap", 16'(func), 16'd3);
    chk("carry_cap", 16'(carry_in), 16'd1);
    enter_val(8'h05);
    chk("a_status", 16'(status), 16'd3);
    chk("a_cap", 16'(op_a), 16'd5);
    sw = 8'h30;
    exp_q.push_back({3'd3, 1'b1, 4'd5, 4'd3});
    key_n[0] = 1'b0;
    w = 0;
    while (!alu_valid && w < 40) begin
      @(negedge clock);
      w++;
    end
    chk("valid_rise", 16'(alu_valid), 16'd1);
    chk("issue_status", 16'(status), 16'd4);
    chk("b_cap", 16'(op_b), 16'd3);
    for (int k = 2; k <= 6; k++) begin
      @(negedge clock);
      chk($sformatf("valid_hold_%0d", k), 16'(alu_valid), 16'd1);
    end
    alu_ready = 1'b1;
    @(negedge clock);
    chk("valid_drop", 16'(alu_valid), 16'd0);
    chk("done_status", 16'(status), 16'd5);
    key_n[0] = 1'b1;
    wait_neg(D + 4);
    chk("done_hold", 16'(status), 16'd5);

    // ready high outside ISSUE is ignored; DONE -> FUNC keeps operands
    enter_val(8'hFF);
    chk("done_exit_status", 16'(status), 16'd1);
    chk_word("held", 3'd3, 1'b1, 4'd5, 4'd3);

    // Clear and enter together in ISSUE
    alu_ready = 1'b0;
    enter_val(8'h02);
    enter_val(8'h0A);
    enter_val(8'hC0);
    chk("issue2_valid", 16'(alu_valid), 16'd1);
    key_n = 2'b00;
    wait_neg(D + 4);
    chk("clr_win_status", 16'(status), 16'd1);
    chk("clr_win_valid", 16'(alu_valid), 16'd0);
    chk_word("clr_win", 3'd0, 1'b0, 4'd0, 4'd0);
    key_n = 2'b11;
    wait_neg(D + 4);
    chk("clr_release", 16'(status), 16'd1);

    // Reset while issuing
    enter_val(8'h0D);
    enter_val(8'h07);
    enter_val(8'h90);
    chk("issue3_valid", 16'(alu_valid), 16'd1);
    chk_word("issue3", 3'd5, 1'b1, 4'd7, 4'd9);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("midrst_status", 16'(status), 16'd1);
    chk("midrst_valid", 16'(alu_valid), 16'd0);
    chk_word("midrst", 3'd0, 1'b0, 4'd0, 4'd0);
    wait_neg(3);

    // func 6 passes through; ready already high gives a one-cycle issue
    alu_ready = 1'b1;
    enter_val(8'h0E);
    enter_val(8'h0F);
    exp_q.push_back({3'd6, 1'b1, 4'hF, 4'd2});
    enter_val(8'h20);
    chk("fast_status", 16'(status), 16'd5);
    chk("fast_valid", 16'(alu_valid), 16'd0);
    alu_ready = 1'b0;
    wait_neg(2);
    chk("scoreboard_drain", 16'(exp_q.size()), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
